// File: rtl/pio_edge_capture_if.sv
// pio_edge_capture_if: CPU register-window bus for the edge-capture block.
// Latency: n/a (wires only); read data is registered inside the slave.
// Backpressure: none; read/write strobes are single-cycle and always accepted.
interface pio_edge_capture_if;
    logic [2:0]  iADDRESS;
    logic        iWRITE;
    logic        iREAD;
    logic [31:0] iWRITE_DATA;
    logic [31:0] oREAD_DATA;

    modport master (
        output iADDRESS, iWRITE, iREAD, iWRITE_DATA,
        input  oREAD_DATA
    );

    modport slave (
        input  iADDRESS, iWRITE, iREAD, iWRITE_DATA,
        output oREAD_DATA
    );
endinterface

// File: rtl/pio_edge_capture.sv
// pio_edge_capture: pin sync, optional debounce (PIO_EDGE_DEBOUNCE_EN), sticky edge flags -> level IRQ.
// Latency: pin->oPIO 2 cycles (5 with debounce, DIV=0), EDGE +1, oIRQ +2; reads return 1 cycle later.
// Backpressure: none; bus strobes are single-cycle and always accepted.
module pio_edge_capture #(
    parameter int pBITS     = 32,
    parameter int pDIV_BITS = 16
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET,
    pio_edge_capture_if.slave    bus,
    input  logic [pBITS-1:0]     iPIN,
    output logic [pBITS-1:0]     oPIO,
    output logic                 oIRQ
);

    if (pBITS < 1 || pBITS > 32 || pDIV_BITS < 1 || pDIV_BITS > 32) begin : g_bad_param
        $error("pio_edge_capture: pBITS and pDIV_BITS must be in 1..32");
    end

    localparam logic [2:0] ADDR_LEVEL   = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN = 3'd1;
    localparam logic [2:0] ADDR_FALL_EN = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_MASK    = 3'd4;
    localparam logic [2:0] ADDR_DIV     = 3'd5;

    logic [pBITS-1:0] s1_q, s2_q;
    logic [pBITS-1:0] filt_q, filt_d, filt_prev_q;
    logic [pBITS-1:0] rise_en_q, fall_en_q, irq_mask_q;
    logic [pBITS-1:0] edge_q, edge_d, edge_clr;
    logic [pBITS-1:0] wdata;
    logic             irq_q;
    logic [31:0]      rdata_q, rdata_d;

    assign wdata    = bus.iWRITE_DATA[pBITS-1:0];
    assign edge_clr = (bus.iWRITE && bus.iADDRESS == ADDR_EDGE) ? wdata : '0;

    // Two-flop synchroniser for the asynchronous pad levels.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= iPIN;
            s2_q <= s1_q;
        end
    end

`ifdef PIO_EDGE_DEBOUNCE_EN
    logic [pDIV_BITS-1:0] div_q, cnt_q, cnt_d;
    logic [pBITS-1:0]     h0_q, h1_q, h2_q, agree;
    logic                 tick, div_wr;

    assign div_wr = bus.iWRITE && bus.iADDRESS == ADDR_DIV;
    assign tick   = (cnt_q == '0);
    assign agree  = ~(h0_q ^ h1_q) & ~(h1_q ^ h2_q);
    // A pin only moves once three consecutive tick samples agree; otherwise it holds.
    assign filt_d = (agree & h0_q) | (~agree & filt_q);

    // Prescaler next value: a DIV write reloads immediately, otherwise count down and wrap.
    always_comb begin
        cnt_d = cnt_q - pDIV_BITS'(1);
        if (div_wr)
            cnt_d = bus.iWRITE_DATA[pDIV_BITS-1:0];
        else if (tick)
            cnt_d = div_q;
    end

    // Prescaler, reload value and per-pin sample history (history shifts only on ticks).
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            div_q <= '0;
            cnt_q <= '0;
            h0_q  <= '0;
            h1_q  <= '0;
            h2_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (div_wr)
                div_q <= bus.iWRITE_DATA[pDIV_BITS-1:0];
            if (tick) begin
                h0_q <= s2_q;
                h1_q <= h0_q;
                h2_q <= h1_q;
            end
        end
    end
`else
    assign filt_d = s2_q;
`endif

    // Rising/falling edges of the clean bus; a same-cycle set overrides a W1C clear.
    assign edge_d = (edge_q & ~edge_clr)
                  | (filt_q & ~filt_prev_q & rise_en_q)
                  | (~filt_q & filt_prev_q & fall_en_q);

    // Filtered levels, their one-cycle delay, sticky flags and the registered interrupt.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            filt_q      <= '0;
            filt_prev_q <= '0;
            edge_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            edge_q      <= edge_d;
            irq_q       <= |(edge_q & irq_mask_q);
        end
    end

    // Software-writable enable and mask registers.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_mask_q <= '0;
        end else if (bus.iWRITE) begin
            case (bus.iADDRESS)
                ADDR_RISE_EN: rise_en_q  <= wdata;
                ADDR_FALL_EN: fall_en_q  <= wdata;
                ADDR_MASK:    irq_mask_q <= wdata;
                default: ;
            endcase
        end
    end

    // Read mux over current (pre-write) register values; data holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.iREAD) begin
            rdata_d = '0;
            case (bus.iADDRESS)
                ADDR_LEVEL:   rdata_d[pBITS-1:0] = filt_q;
                ADDR_RISE_EN: rdata_d[pBITS-1:0] = rise_en_q;
                ADDR_FALL_EN: rdata_d[pBITS-1:0] = fall_en_q;
                ADDR_EDGE:    rdata_d[pBITS-1:0] = edge_q;
                ADDR_MASK:    rdata_d[pBITS-1:0] = irq_mask_q;
`ifdef PIO_EDGE_DEBOUNCE_EN
                ADDR_DIV:     rdata_d[pDIV_BITS-1:0] = div_q;
`endif
                default: ;
            endcase
        end
    end

    // Registered read data.
    always_ff @(posedge iCLOCK) begin
        if (iRESET)
            rdata_q <= '0;
        else
            rdata_q <= rdata_d;
    end

    assign bus.oREAD_DATA = rdata_q;
    assign oPIO           = filt_q;
    assign oIRQ           = irq_q;

endmodule

// File: tb/tb_pio_edge_capture.sv
// tb_pio_edge_capture: register table, random traffic against a behavioural model, directed corners.
// Latency: n/a.
// Backpressure: n/a.
module tb_pio_edge_capture;

`ifdef PIO_EDGE_DEBOUNCE_EN
    localparam int L = 3;          // newest pin sample seen by the filter, in edges ago
    localparam int W = 3;          // agreement window
    localparam int LAT_PIO = 5;
    localparam logic [31:0] DIV_RB = 32'h0000_1234;
`else
    localparam int L = 2;
    localparam int W = 1;
    localparam int LAT_PIO = 2;
    localparam logic [31:0] DIV_RB = 32'h0;
`endif
    localparam int LAT_EDGE = LAT_PIO + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pin = '0;
    logic [31:0] pio;
    logic        irq;
    int          errors = 0;
    int          checks = 0;

    pio_edge_capture_if bus();

    pio_edge_capture #(.pBITS(32), .pDIV_BITS(16)) dut (
        .iCLOCK (clk),
        .iRESET (rst),
        .bus    (bus),
        .iPIN   (pin),
        .oPIO   (pio),
        .oIRQ   (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: filtered level = pin sample L edges ago once W samples agree.
    logic [31:0] m_hist [0:7];
    logic [31:0] m_filt, m_prev, m_edge, m_rise, m_fall, m_mask, m_rd;
    logic [15:0] m_div;
    logic        m_irq;

    task automatic model_step();
        logic [31:0] nf, ne, clr, wd;
        logic        agree;
        if (rst) begin
            for (int j = 0; j < 8; j++) m_hist[j] = '0;
            m_filt = '0; m_prev = '0; m_edge = '0; m_rise = '0;
            m_fall = '0; m_mask = '0; m_rd = '0; m_div = '0; m_irq = 1'b0;
        end else begin
            wd = bus.iWRITE_DATA;
            for (int j = 7; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = pin;
            nf = m_filt;
            for (int b = 0; b < 32; b++) begin
                agree = 1'b1;
                for (int w = 1; w < W; w++)
                    if (m_hist[L+w][b] !== m_hist[L][b]) agree = 1'b0;
                if (agree) nf[b] = m_hist[L][b];
            end
            clr = (bus.iWRITE && bus.iADDRESS == 3'd3) ? wd : '0;
            ne = (m_edge & ~clr) | (m_filt & ~m_prev & m_rise) | (~m_filt & m_prev & m_fall);
            m_irq = |(m_edge & m_mask);
            if (bus.iREAD) begin
                case (bus.iADDRESS)
                    3'd0: m_rd = m_filt;
                    3'd1: m_rd = m_rise;
                    3'd2: m_rd = m_fall;
                    3'd3: m_rd = m_edge;
                    3'd4: m_rd = m_mask;
                    3'd5: m_rd = {16'h0, m_div};
                    default: m_rd = '0;
                endcase
            end
            if (bus.iWRITE) begin
                case (bus.iADDRESS)
                    3'd1: m_rise = wd;
                    3'd2: m_fall = wd;
                    3'd4: m_mask = wd;
`ifdef PIO_EDGE_DEBOUNCE_EN
                    3'd5: m_div  = wd[15:0];
`endif
                    default: ;
                endcase
            end
            m_prev = m_filt;
            m_filt = nf;
            m_edge = ne;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.iADDRESS = a; bus.iWRITE_DATA = d; bus.iWRITE = 1'b1;
        tick();
        bus.iWRITE = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.iADDRESS = a; bus.iREAD = 1'b1;
        tick();
        bus.iREAD = 1'b0;
        d = bus.oREAD_DATA;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t    tbl [8];
    logic [31:0] rd;
    logic        wr_c, rd_c, seen;

    initial begin
        tbl[0] = '{3'd1, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        tbl[1] = '{3'd2, 32'h1234_5678, 32'h1234_5678};
        tbl[2] = '{3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[3] = '{3'd5, 32'hFFFF_1234, DIV_RB};
        tbl[4] = '{3'd6, 32'hDEAD_BEEF, 32'h0};
        tbl[5] = '{3'd7, 32'hCAFE_F00D, 32'h0};
        tbl[6] = '{3'd0, 32'hFFFF_FFFF, 32'h0};
        tbl[7] = '{3'd3, 32'hFFFF_FFFF, 32'h0};

        bus.iADDRESS = '0; bus.iWRITE = 1'b0; bus.iREAD = 1'b0; bus.iWRITE_DATA = '0;

        // Reset with all pins high: everything reads back zero.
        pin = 32'hFFFF_FFFF;
        do_reset();
        pin = '0;
        chk("reset_pio", pio, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_rdata", bus.oREAD_DATA, 32'h0);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            chk($sformatf("reset_reg%0d", a), rd, 32'h0);
        end

        // Register write/readback table.
        for (int i = 0; i < 8; i++) begin
            bus_write(tbl[i].addr, tbl[i].wdata);
            bus_read(tbl[i].addr, rd);
            chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
        end
        bus_write(3'd1, '0); bus_write(3'd2, '0); bus_write(3'd4, '0); bus_write(3'd5, '0);

        // Random traffic against the model (DIV stays 0).
        for (int c = 0; c < 600; c++) begin
            pin = pin ^ ($urandom & $urandom & $urandom & $urandom);
            wr_c = ($urandom_range(0, 3) == 0);
            rd_c = ($urandom_range(0, 2) == 0);
            bus.iWRITE = wr_c; bus.iREAD = rd_c;
            bus.iWRITE_DATA = $urandom;
            if (wr_c) begin
                case ($urandom_range(0, 3))
                    0: bus.iADDRESS = 3'd1;
                    1: bus.iADDRESS = 3'd2;
                    2: bus.iADDRESS = 3'd3;
                    default: bus.iADDRESS = 3'd4;
                endcase
            end else begin
                bus.iADDRESS = 3'($urandom_range(0, 7));
            end
            tick();
            chk("rand_pio", pio, m_filt);
            chk("rand_irq", {31'b0, irq}, {31'b0, m_irq});
            if (rd_c) chk("rand_rdata", bus.oREAD_DATA, m_rd);
        end
        bus.iWRITE = 1'b0; bus.iREAD = 1'b0; pin = '0;

        // Rising edge on pin 0: exact oPIO / oIRQ latency, then W1C drops IRQ one cycle later.
        do_reset();
        bus_write(3'd1, 32'h1);
        bus_write(3'd4, 32'h1);
        pin[0] = 1'b1;
        tick();
        repeat (LAT_PIO - 1) tick();
        chk("rise_pio_early", {31'b0, pio[0]}, 32'h0);
        tick();
        chk("rise_pio", {31'b0, pio[0]}, 32'h1);
        tick();
        chk("rise_irq_early", {31'b0, irq}, 32'h0);
        tick();
        chk("rise_irq", {31'b0, irq}, 32'h1);
        bus_read(3'd3, rd);
        chk("rise_edge", rd, 32'h1);
        bus_write(3'd3, 32'h1);
        chk("w1c_irq_hold", {31'b0, irq}, 32'h1);
        tick();
        chk("w1c_irq_drop", {31'b0, irq}, 32'h0);

        // Falling edge on pin 7 captured while masked; unmasking raises IRQ.
        pin[7] = 1'b1;
        repeat (12) tick();
        bus_write(3'd3, 32'hFFFF_FFFF);
        bus_write(3'd1, 32'h0);
        bus_write(3'd2, 32'h80);
        bus_write(3'd4, 32'h0);
        pin[7] = 1'b0;
        seen = 1'b0;
        repeat (LAT_EDGE + 2) begin
            tick();
            seen = seen | irq;
        end
        chk("fall_irq_masked", {31'b0, seen}, 32'h0);
        bus_read(3'd3, rd);
        chk("fall_edge", rd, 32'h80);
        bus_write(3'd4, 32'h80);
        chk("unmask_irq_early", {31'b0, irq}, 32'h0);
        tick();
        chk("unmask_irq", {31'b0, irq}, 32'h1);

        // Set beats clear on pin 1.
        bus_write(3'd4, 32'h0);
        bus_write(3'd2, 32'h0);
        bus_write(3'd1, 32'h2);
        bus_write(3'd3, 32'hFFFF_FFFF);
        bus_read(3'd3, rd);
        chk("clear_all", rd, 32'h0);
        pin[1] = 1'b1;
        tick();
        repeat (LAT_EDGE - 1) tick();
        bus_write(3'd3, 32'h2);
        bus_read(3'd3, rd);
        chk("set_beats_clear", rd, 32'h2);
        bus_write(3'd3, 32'h2);
        bus_read(3'd3, rd);
        chk("clear_after", rd, 32'h0);

`ifdef PIO_EDGE_DEBOUNCE_EN
        // Glitch rejection with DIV=3, then a long level passes.
        bus_write(3'd1, 32'h20);
        bus_write(3'd5, 32'h3);
        pin[5] = 1'b1;
        repeat (8) tick();
        pin[5] = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen = seen | pio[5];
        end
        chk("glitch_pio", {31'b0, seen}, 32'h0);
        bus_read(3'd3, rd);
        chk("glitch_edge", rd, 32'h0);
        pin[5] = 1'b1;
        repeat (20) tick();
        chk("long_pio", {31'b0, pio[5]}, 32'h1);
        bus_read(3'd3, rd);
        chk("long_edge", rd, 32'h20);
`else
        // Without debounce a single-cycle pulse is captured and DIV is absent.
        bus_write(3'd1, 32'h4);
        pin[2] = 1'b1;
        tick();
        pin[2] = 1'b0;
        repeat (6) tick();
        bus_read(3'd3, rd);
        chk("pulse_edge", rd, 32'h4);
        bus_write(3'd5, 32'h1234);
        bus_read(3'd5, rd);
        chk("div_absent", rd, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
